// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : 1024x768@60 raster timing generator (counters, sync, blank,
//            line/frame markers). Optional VGA_TIMING_CE_EN adds a ce port.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int unsigned H_TOTAL      = 1344,
    parameter int unsigned H_ACTIVE     = 1024,
    parameter int unsigned H_SYNC_START = 1048,
    parameter int unsigned H_SYNC_END   = 1184,
    parameter int unsigned V_TOTAL      = 806,
    parameter int unsigned V_ACTIVE     = 768,
    parameter int unsigned V_SYNC_START = 771,
    parameter int unsigned V_SYNC_END   = 777
) (
    input  logic        clk,
    input  logic        rst,
`ifdef VGA_TIMING_CE_EN
    input  logic        ce,
`endif
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic        line_start,
    output logic        frame_start
);

    localparam logic [10:0] c_H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] c_H_ACTIVE     = 11'(H_ACTIVE);
    localparam logic [10:0] c_H_SYNC_START = 11'(H_SYNC_START);
    localparam logic [10:0] c_H_SYNC_END   = 11'(H_SYNC_END);
    localparam logic [10:0] c_V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [10:0] c_V_ACTIVE     = 11'(V_ACTIVE);
    localparam logic [10:0] c_V_SYNC_START = 11'(V_SYNC_START);
    localparam logic [10:0] c_V_SYNC_END   = 11'(V_SYNC_END);

    generate
        if (!((H_ACTIVE < H_SYNC_START) && (H_SYNC_START < H_SYNC_END) &&
              (H_SYNC_END <= H_TOTAL) && (H_TOTAL <= 2048) &&
              (V_ACTIVE < V_SYNC_START) && (V_SYNC_START < V_SYNC_END) &&
              (V_SYNC_END <= V_TOTAL) && (V_TOTAL <= 2048))) begin : g_cfg_error
            $error("vga_timing_gen: inconsistent timing parameters");
        end
    endgenerate

    logic        w_adv;
`ifdef VGA_TIMING_CE_EN
    assign w_adv = ce;
`else
    assign w_adv = 1'b1;
`endif

    logic [10:0] r_hcount, r_vcount;
    logic        r_hsync, r_vsync, r_hblnk, r_vblnk, r_line_start, r_frame_start;

    logic [10:0] w_hcount_nxt, w_vcount_nxt;
    logic        w_h_wrap, w_v_wrap;

    // Flags are derived from the next counts so they land with those counts.
    always_comb begin
        w_h_wrap     = (r_hcount == c_H_LAST);
        w_v_wrap     = (r_vcount == c_V_LAST);
        w_hcount_nxt = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
        w_vcount_nxt = r_vcount;
        if (w_h_wrap) begin
            w_vcount_nxt = w_v_wrap ? 11'd0 : r_vcount + 11'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcount      <= 11'd0;
            r_vcount      <= 11'd0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_adv) begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hsync       <= (w_hcount_nxt >= c_H_SYNC_START) && (w_hcount_nxt < c_H_SYNC_END);
            r_vsync       <= (w_vcount_nxt >= c_V_SYNC_START) && (w_vcount_nxt < c_V_SYNC_END);
            r_hblnk       <= (w_hcount_nxt >= c_H_ACTIVE);
            r_vblnk       <= (w_vcount_nxt >= c_V_ACTIVE);
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_h_wrap && w_v_wrap;
        end
    end

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hblnk       = r_hblnk;
    assign vblnk       = r_vblnk;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Directed bench: full-size instance for horizontal timing, a
//            reduced-geometry instance for vertical/frame timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b1;

    always #8 clk = ~clk;

    logic [10:0] d_hcount, d_vcount, s_hcount, s_vcount;
    logic d_hsync, d_vsync, d_hblnk, d_vblnk, d_line_start, d_frame_start;
    logic s_hsync, s_vsync, s_hblnk, s_vblnk, s_line_start, s_frame_start;

    vga_timing_gen dut (
        .clk(clk), .rst(rst),
`ifdef VGA_TIMING_CE_EN
        .ce(ce),
`endif
        .hcount(d_hcount), .vcount(d_vcount), .hsync(d_hsync), .vsync(d_vsync),
        .hblnk(d_hblnk), .vblnk(d_vblnk), .line_start(d_line_start),
        .frame_start(d_frame_start)
    );

    // 16x8 raster: hblank 10..15, hsync 11..13, vblank 5..7, vsync 6..7
    vga_timing_gen #(
        .H_TOTAL(16), .H_ACTIVE(10), .H_SYNC_START(11), .H_SYNC_END(14),
        .V_TOTAL(8),  .V_ACTIVE(5),  .V_SYNC_START(6),  .V_SYNC_END(8)
    ) dut_s (
        .clk(clk), .rst(rst),
`ifdef VGA_TIMING_CE_EN
        .ce(ce),
`endif
        .hcount(s_hcount), .vcount(s_vcount), .hsync(s_hsync), .vsync(s_vsync),
        .hblnk(s_hblnk), .vblnk(s_vblnk), .line_start(s_line_start),
        .frame_start(s_frame_start)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " d_hcount"}, d_hcount, 0);
        chk({tag, " d_vcount"}, d_vcount, 0);
        chk({tag, " d_flags"}, {d_hsync, d_vsync, d_hblnk, d_vblnk, d_line_start, d_frame_start}, 0);
        chk({tag, " s_hcount"}, s_hcount, 0);
        chk({tag, " s_vcount"}, s_vcount, 0);
        chk({tag, " s_flags"}, {s_hsync, s_vsync, s_hblnk, s_vblnk, s_line_start, s_frame_start}, 0);
    endtask

    initial begin
        int n, nv, nb, nh, nl, nf, mh, mv;

        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Full-size horizontal line walk
        step(1);
        chk("first d_hcount", d_hcount, 1);
        chk("first d_frame_start", d_frame_start, 0);
        chk("first d_line_start", d_line_start, 0);
        step(1022);
        chk("h1023 hblnk", d_hblnk, 0);
        step(1);
        chk("h1024 hcount", d_hcount, 1024);
        chk("h1024 hblnk", d_hblnk, 1);
        chk("h1024 hsync", d_hsync, 0);
        step(23);
        chk("h1047 hsync", d_hsync, 0);
        step(1);
        chk("h1048 hsync", d_hsync, 1);
        step(135);
        chk("h1183 hsync", d_hsync, 1);
        step(1);
        chk("h1184 hsync", d_hsync, 0);
        step(159);
        chk("h1343 hcount", d_hcount, 1343);
        chk("h1343 vcount", d_vcount, 0);
        chk("h1343 hblnk", d_hblnk, 1);
        chk("h1343 hsync", d_hsync, 0);
        step(1);
        chk("wrap hcount", d_hcount, 0);
        chk("wrap vcount", d_vcount, 1);
        chk("wrap line_start", d_line_start, 1);
        chk("wrap frame_start", d_frame_start, 0);
        chk("wrap hblnk", d_hblnk, 0);
        chk("wrap vblnk", d_vblnk, 0);
        chk("wrap vsync", d_vsync, 0);
        step(1);
        chk("after wrap line_start", d_line_start, 0);

        // Asynchronous mid-frame reset between clock edges
        step(499);
        chk("pre-reset hcount", d_hcount, 500);
        chk("pre-reset vcount", d_vcount, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("async reset");
        @(negedge clk) rst = 1'b0;
        step(1);
        chk("restart hcount", d_hcount, 1);
        chk("restart vcount", d_vcount, 0);
        chk("restart d_frame_start", d_frame_start, 0);
        chk("restart s_frame_start", s_frame_start, 0);
        chk("restart s_line_start", s_line_start, 0);

        // Reduced raster: first frame_start arrives 128 clocks after release
        n = 1;
        while (s_frame_start !== 1'b1 && n < 300) begin
            step(1);
            n++;
        end
        chk("first frame_start clocks", n, 128);
        chk("frame hcount", s_hcount, 0);
        chk("frame vcount", s_vcount, 0);
        chk("frame line_start", s_line_start, 1);

        nv = 0; nb = 0; nh = 0; nl = 0; nf = 0; mh = 0; mv = 0;
        for (int i = 0; i < 128; i++) begin
            step(1);
            nv += int'(s_vsync);
            nb += int'(s_vblnk);
            nh += int'(s_hsync);
            nl += int'(s_line_start);
            nf += int'(s_frame_start);
            if (int'(s_hcount) > mh) mh = int'(s_hcount);
            if (int'(s_vcount) > mv) mv = int'(s_vcount);
            if (s_vcount == 11'd6 && s_hcount == 11'd0)
                chk("vsync rise", s_vsync, 1);
            if (s_vcount == 11'd5 && s_hcount == 11'd15)
                chk("vsync before", s_vsync, 0);
        end
        chk("vsync cycles", nv, 32);
        chk("vblnk cycles", nb, 48);
        chk("hsync cycles", nh, 24);
        chk("line_start pulses", nl, 8);
        chk("frame_start pulses", nf, 1);
        chk("max hcount", mh, 15);
        chk("max vcount", mv, 7);
        chk("second frame_start", s_frame_start, 1);
        chk("frame vsync off", s_vsync, 0);
        chk("frame vblnk off", s_vblnk, 0);

`ifdef VGA_TIMING_CE_EN
        ce = 1'b0;
        step(3);
        chk("ce0 frame_start held", s_frame_start, 1);
        chk("ce0 line_start held", s_line_start, 1);
        chk("ce0 s_hcount held", s_hcount, 0);
        chk("ce0 d_hcount held", d_hcount, 256);
        ce = 1'b1;
        step(1);
        chk("ce1 d_hcount", d_hcount, 257);
        chk("ce1 s_hcount", s_hcount, 1);
        chk("ce1 frame_start", s_frame_start, 0);
        for (int i = 0; i < 16; i++) begin
            ce = 1'b0;
            step(1);
            ce = 1'b1;
            step(1);
        end
        chk("toggle d_hcount", d_hcount, 273);
        chk("toggle s_hcount", s_hcount, 1);
        chk("toggle s_vcount", s_vcount, 1);
        ce = 1'b0;
        step(1);
        chk("toggle frozen", d_hcount, 273);
        ce = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
